tx_arbiter: RTL and testbench
=============================

Name: tx_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 8-bit serial byte transmitter between NUM_REQ requesters.
- Each requester presents a byte with a valid/ready handshake. The arbiter grants one requester, latches its byte, and launches a frame with a clean rising edge on tx_send.
- It tracks the transmitter's 2-bit state output until the frame ends, then optionally idles GAP_CYCLES before the next grant.
- Sits between the byte producers and the transmitter; the transmitter's txd pin goes off-chip untouched.

Parameters:
- NUM_REQ, 4: number of requesters; legal range 2..8.
- GAP_CYCLES, 0: extra idle cycles inserted after each frame completes; legal range 0..255.
- ID_W, 2: width of grant_id; must be >= clog2(NUM_REQ).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester byte-valid.
- req_data  in  8*NUM_REQ  per-requester byte; requester i occupies bits [8i+7:8i].
- req_ready  out  NUM_REQ  one-hot grant; combinational.
- tx_send  out  1  registered launch strobe to the transmitter.
- tx_data  out  8  registered byte to the transmitter.
- tx_state  in  2  transmitter state: 00 idle, 01 start, 10 data bits, 11 stop.
- grant_id  out  ID_W  index of the last granted requester; registered.
- busy  out  1  high when the controller state is not IDLE.
- err  out  1  sticky watchdog error; only active with the optional feature.

Behaviour:
- Reset values:
  - state = IDLE; tx_send = 0; tx_data = 0x00; grant_id = 0; err = 0.
  - Round-robin pointer = NUM_REQ-1, so requester 0 has first priority.
- States:
  - IDLE -> LAUNCH -> WAIT_DONE -> GAP (only if GAP_CYCLES > 0) -> IDLE.
- IDLE:
  - req_ready is asserted only in IDLE with tx_state == 00.
  - It goes to the first requester with req_valid=1, searching from pointer+1 upward with wrap-around.
  - At most one bit of req_ready is set.
  - A handshake is the cycle where req_valid[i] & req_ready[i] are both high. On that edge:
    - tx_data <= req_data[i]; grant_id <= i; pointer <= i; tx_send <= 1; state <= LAUNCH.
  - If no requester is valid, or tx_state != 00 (e.g. after a reset taken mid-frame), stay in IDLE with tx_send = 0.
- LAUNCH:
  - tx_send stays 1 and tx_data is held.
  - When tx_state != 00: tx_send <= 0; state <= WAIT_DONE.
- WAIT_DONE:
  - tx_data is held.
  - When tx_state == 00: go to GAP, loading the gap counter with GAP_CYCLES-1, or go to IDLE if GAP_CYCLES == 0.
- GAP:
  - Decrement the counter; go to IDLE when it reaches 0.
- Timing, with the handshake in cycle 0:
  - tx_send is high in cycles 1-2.
  - tx_state is 01 in cycle 2, 10 in cycles 3-10, 11 in cycle 11, and 00 in cycle 12.
  - IDLE is reached in cycle 13+GAP_CYCLES, which is also the earliest next handshake.
  - Back-to-back frame period = 13 + GAP_CYCLES cycles.
- Edge guarantee: tx_send is low for at least one cycle between frames, so the transmitter's edge detector always sees 0->1.
- If a requester drops req_valid before its handshake: no transfer and no pointer change.
- Simultaneous requests are granted in strict rotation. A requester that holds valid continuously waits at most NUM_REQ-1 frames.
- tx_data is stable from the cycle tx_send rises until tx_state leaves 00.
- rst in any state returns to IDLE on the next edge. An in-flight frame in the transmitter is not aborted; the next grant waits for tx_state == 00.

Optional Feature:
- Macro: TX_ARB_TIMEOUT_EN.
- When defined, a 6-bit watchdog counter runs in LAUNCH and WAIT_DONE:
  - LAUNCH lasting more than 15 cycles, or WAIT_DONE more than 31 cycles, sets err = 1.
  - On timeout: tx_send <= 0 and state <= IDLE; the byte is dropped and the pointer keeps the granted index.
  - err clears only on rst.
- When not defined: err is tied 0, there is no counter, and the controller waits indefinitely.

Test Plan:
- Reset, then req_valid=0001, req_data[0]=0xA5 -> req_ready=0001 in cycle 0; tx_data=0xA5 and tx_send=1 in cycles 1-2; grant_id=0; busy returns low in cycle 13.
- All four valid, holding data 0x11/0x22/0x33/0x44 -> frames carry 0x11, 0x22, 0x33, 0x44, 0x11 in that order; handshakes are 13 cycles apart.
- GAP_CYCLES=3, two back-to-back requests -> second handshake occurs 16 cycles after the first; tx_send is low for at least 12 consecutive cycles between frames.
- Assert rst while tx_state=10, keep the model transmitter running, and hold req_valid[2] -> no req_ready until tx_state returns to 00, then grant to requester 2 with tx_send rising cleanly.
- Requester 1 pulses valid only in a cycle where the controller is in WAIT_DONE -> no ready for requester 1 and the pointer is unchanged.
- With TX_ARB_TIMEOUT_EN, tie tx_state=00 -> tx_send drops after 16 LAUNCH cycles, err=1 and sticky, state returns to IDLE. Without the macro, the same stimulus keeps tx_send=1 and err=0.

Source files
------------

// File: rtl/tx_arbiter_if.sv
// Requester-side byte bus: per-requester valid/data in, one-hot ready out.
interface tx_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;

  modport master (
    output req_valid,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_data,
    output req_ready
  );
endinterface

// File: rtl/tx_arbiter.sv
// Round-robin arbiter that sequences NUM_REQ byte producers onto one serial
// byte transmitter. Optional launch/frame watchdog: define TX_ARB_TIMEOUT_EN.
module tx_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned GAP_CYCLES = 0,
  parameter int unsigned ID_W       = 2
) (
  input  logic            clk,
  input  logic            rst,
  tx_arbiter_if.slave     req_if,
  output logic            tx_send,
  output logic [7:0]      tx_data,
  input  logic [1:0]      tx_state,
  output logic [ID_W-1:0] grant_id,
  output logic            busy,
  output logic            err
);

  localparam int unsigned PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned GAP_W   = 8;
  localparam logic [1:0]  TX_IDLE = 2'b00;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LAUNCH    = 2'd1,
    S_WAIT_DONE = 2'd2,
    S_GAP       = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic               tx_send_q, tx_send_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic [ID_W-1:0]    grant_id_q, grant_id_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               busy_q, busy_d;
`ifdef TX_ARB_TIMEOUT_EN
  logic [5:0]         wd_q, wd_d;
  logic               err_q, err_d;
`endif

  logic [PTR_W:0]     cand;
  logic [PTR_W-1:0]   pick_idx;
  logic               pick_found;
  logic               hs_c;
  logic [NUM_REQ-1:0] ready_c;

  // Round-robin search: first valid requester after the pointer, with wrap.
  always_comb begin
    cand       = '0;
    pick_idx   = '0;
    pick_found = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, ptr_q} + (PTR_W+1)'(k);
      if (cand >= (PTR_W+1)'(NUM_REQ)) begin
        cand = cand - (PTR_W+1)'(NUM_REQ);
      end
      if (!pick_found && req_if.req_valid[cand[PTR_W-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[PTR_W-1:0];
      end
    end
  end

  // State register and all controller flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ptr_q      <= PTR_W'(NUM_REQ - 1);
      tx_send_q  <= 1'b0;
      tx_data_q  <= 8'h00;
      grant_id_q <= '0;
      gap_q      <= '0;
      busy_q     <= 1'b0;
`ifdef TX_ARB_TIMEOUT_EN
      wd_q       <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      tx_send_q  <= tx_send_d;
      tx_data_q  <= tx_data_d;
      grant_id_q <= grant_id_d;
      gap_q      <= gap_d;
      busy_q     <= busy_d;
`ifdef TX_ARB_TIMEOUT_EN
      wd_q       <= wd_d;
      err_q      <= err_d;
`endif
    end
  end

  // Next-state logic: grant, launch, track the frame, optional idle gap.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    tx_send_d  = tx_send_q;
    tx_data_d  = tx_data_q;
    grant_id_d = grant_id_q;
    gap_d      = gap_q;
`ifdef TX_ARB_TIMEOUT_EN
    wd_d       = wd_q;
    err_d      = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        tx_send_d = 1'b0;
        if (hs_c) begin
          tx_data_d  = req_if.req_data[{pick_idx, 3'b000} +: 8];
          grant_id_d = ID_W'(pick_idx);
          ptr_d      = pick_idx;
          tx_send_d  = 1'b1;
          state_d    = S_LAUNCH;
`ifdef TX_ARB_TIMEOUT_EN
          wd_d       = '0;
`endif
        end
      end
      S_LAUNCH: begin
        if (tx_state != TX_IDLE) begin
          tx_send_d = 1'b0;
          state_d   = S_WAIT_DONE;
`ifdef TX_ARB_TIMEOUT_EN
          wd_d      = '0;
        end else if (wd_q == 6'd15) begin
          err_d     = 1'b1;
          tx_send_d = 1'b0;
          state_d   = S_IDLE;
        end else begin
          wd_d      = wd_q + 6'd1;
`endif
        end
      end
      S_WAIT_DONE: begin
        if (tx_state == TX_IDLE) begin
          if (GAP_CYCLES == 0) begin
            state_d = S_IDLE;
          end else begin
            gap_d   = GAP_W'(GAP_CYCLES - 1);
            state_d = S_GAP;
          end
`ifdef TX_ARB_TIMEOUT_EN
        end else if (wd_q == 6'd31) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          wd_d    = wd_q + 6'd1;
`endif
        end
      end
      S_GAP: begin
        if (gap_q == '0) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // Outputs: combinational one-hot ready, everything else from flops.
  always_comb begin
    ready_c = '0;
    hs_c    = 1'b0;
    if ((state_q == S_IDLE) && (tx_state == TX_IDLE) && pick_found && !rst) begin
      ready_c[pick_idx] = 1'b1;
      hs_c              = 1'b1;
    end
  end

  assign req_if.req_ready = ready_c;
  assign tx_send          = tx_send_q;
  assign tx_data          = tx_data_q;
  assign grant_id         = grant_id_q;
  assign busy             = busy_q;
`ifdef TX_ARB_TIMEOUT_EN
  assign err              = err_q;
`else
  assign err              = 1'b0;
`endif

endmodule

// File: tb/tb_tx_arbiter.sv
// Bench for tx_arbiter: two instances (no gap, 3-cycle gap), each driving a
// behavioural byte transmitter; grants checked against a rotation model.
module tb_tx_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] vld [2];
  logic [31:0] dat [2];
  logic [3:0] rdy [2];
  logic       snd [2];
  logic [7:0] txd [2];
  logic [1:0] txs [2];
  logic [1:0] gid [2];
  logic       bsy [2];
  logic       er  [2];

  int         cyc = 0;
  int         n_checks = 0;
  int         n_errs = 0;
  int         ptr [2];
  int         gapc [2] = '{0, 3};
  logic       force_idle [2];
  int         tcnt [2] = '{0, 0};
  logic       tprev [2] = '{1'b0, 1'b0};
  logic [7:0] frames0 [$];
  logic [7:0] frames3 [$];
  logic [7:0] exp0 [$];
  logic [7:0] exp3 [$];

  tx_arbiter_if #(.NUM_REQ(4)) if0 ();
  tx_arbiter_if #(.NUM_REQ(4)) if3 ();

  assign if0.req_valid = vld[0];
  assign if0.req_data  = dat[0];
  assign rdy[0]        = if0.req_ready;
  assign if3.req_valid = vld[1];
  assign if3.req_data  = dat[1];
  assign rdy[1]        = if3.req_ready;

  tx_arbiter #(.NUM_REQ(4), .GAP_CYCLES(0), .ID_W(2)) dut0 (
    .clk(clk), .rst(rst), .req_if(if0),
    .tx_send(snd[0]), .tx_data(txd[0]), .tx_state(txs[0]),
    .grant_id(gid[0]), .busy(bsy[0]), .err(er[0])
  );

  tx_arbiter #(.NUM_REQ(4), .GAP_CYCLES(3), .ID_W(2)) dut3 (
    .clk(clk), .rst(rst), .req_if(if3),
    .tx_send(snd[1]), .tx_data(txd[1]), .tx_state(txs[1]),
    .grant_id(gid[1]), .busy(bsy[1]), .err(er[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter model: 01 for one cycle, 10 for eight, 11 for one, after a 0->1 on tx_send.
  function automatic logic [1:0] tstate(input int c);
    if (c == 0) return 2'b00;
    if (c == 1) return 2'b01;
    if (c <= 9) return 2'b10;
    return 2'b11;
  endfunction

  assign txs[0] = tstate(tcnt[0]);
  assign txs[1] = tstate(tcnt[1]);

  always @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      tprev[s] <= snd[s];
      if (force_idle[s]) tcnt[s] <= 0;
      else if (tcnt[s] != 0) tcnt[s] <= (tcnt[s] == 10) ? 0 : tcnt[s] + 1;
      else if (snd[s] && !tprev[s]) begin
        tcnt[s] <= 1;
        if (s == 0) frames0.push_back(txd[s]);
        else frames3.push_back(txd[s]);
      end
    end
  end

  // Rotation model: first valid requester after the last grant.
  function automatic int pick(input int p, input logic [3:0] m);
    for (int k = 1; k <= 4; k++) if (m[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Sample each cycle until a handshake; count cycles with tx_send low.
  task automatic wait_hs(input int s, input int max, output int at,
                         output logic [3:0] rv, output int lows);
    lows = 0;
    at   = -1;
    rv   = '0;
    for (int k = 0; k < max; k++) begin
      #1;
      if (!snd[s]) lows++;
      if ((vld[s] & rdy[s]) != 4'b0000) begin
        at = cyc;
        rv = rdy[s];
        break;
      end
      @(negedge clk);
    end
    chk("hs_seen", 32'(at >= 0), 32'd1);
  endtask

  task automatic wait_idle(input int s);
    int k;
    for (k = 0; k < 60; k++) begin
      if (!bsy[s] && txs[s] == 2'b00) break;
      @(negedge clk);
    end
    chk("idle_reached", 32'(k < 60), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ptr[0] = 3;
    ptr[1] = 3;
  endtask

  // Run n back-to-back frames; optionally re-randomise mask/data after each grant.
  task automatic frames(input int s, input int n, input bit rnd);
    int at, prev, lows, e;
    logic [3:0] rv;
    logic [7:0] b;
    prev = 0;
    for (int r = 0; r < n; r++) begin
      wait_hs(s, 60, at, rv, lows);
      e = pick(ptr[s], vld[s]);
      chk("hs_ready", 32'(rv), 32'(1 << e));
      if (r > 0) begin
        chk("hs_period", 32'(at - prev), 32'(13 + gapc[s]));
        chk("send_low_run", 32'(lows), 32'(11 + gapc[s]));
      end
      b = dat[s][8*e +: 8];
      ptr[s] = e;
      prev = at;
      if (s == 0) exp0.push_back(b);
      else exp3.push_back(b);
      @(negedge clk);
      chk("grant_id", 32'(gid[s]), 32'(e));
      chk("tx_data", 32'(txd[s]), 32'(b));
      chk("tx_send_rise", 32'(snd[s]), 32'd1);
      if (r == n - 1) vld[s] = '0;
      else if (rnd) begin
        vld[s] = 4'($urandom_range(1, 15));
        dat[s] = $urandom();
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int at, lows, e, h, highs, k;
    logic [3:0] rv;

    rst = 1'b1;
    vld[0] = '0; vld[1] = '0;
    dat[0] = '0; dat[1] = '0;
    force_idle[0] = 1'b0; force_idle[1] = 1'b0;
    ptr[0] = 3; ptr[1] = 3;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset values on both instances
    for (int s = 0; s < 2; s++) begin
      chk("rst_tx_send", 32'(snd[s]), 32'd0);
      chk("rst_tx_data", 32'(txd[s]), 32'h00);
      chk("rst_grant_id", 32'(gid[s]), 32'd0);
      chk("rst_busy", 32'(bsy[s]), 32'd0);
      chk("rst_err", 32'(er[s]), 32'd0);
    end

    // Single request from requester 0
    vld[0] = 4'b0001;
    dat[0] = 32'h000000A5;
    #1;
    chk("t1_ready", 32'(rdy[0]), 32'h1);
    h = cyc;
    ptr[0] = 0;
    exp0.push_back(8'hA5);
    @(negedge clk);
    vld[0] = '0;
    chk("t1_send_c1", 32'(snd[0]), 32'd1);
    chk("t1_data_c1", 32'(txd[0]), 32'hA5);
    chk("t1_grant", 32'(gid[0]), 32'd0);
    chk("t1_busy", 32'(bsy[0]), 32'd1);
    @(negedge clk);
    chk("t1_send_c2", 32'(snd[0]), 32'd1);
    @(negedge clk);
    chk("t1_send_c3", 32'(snd[0]), 32'd0);
    for (k = 0; k < 30; k++) begin
      @(negedge clk);
      if (!bsy[0]) break;
    end
    chk("t1_busy_low_cycle", 32'(cyc - h), 32'd13);

    // All four valid: strict rotation 11,22,33,44,11
    do_reset();
    dat[0] = 32'h44332211;
    vld[0] = 4'b1111;
    frames(0, 5, 1'b0);
    wait_idle(0);

    // Gap instance: two back-to-back requests, then random traffic
    dat[1] = 32'h0000C35A;
    vld[1] = 4'b0011;
    frames(1, 2, 1'b0);
    wait_idle(1);
    vld[1] = 4'($urandom_range(1, 15));
    dat[1] = $urandom();
    frames(1, 6, 1'b1);
    wait_idle(1);

    // Reset taken mid-frame; requester 2 must wait for the transmitter
    vld[0] = 4'b0001;
    dat[0] = 32'h007E0055;
    wait_hs(0, 40, at, rv, lows);
    h = at;
    ptr[0] = 0;
    exp0.push_back(8'h55);
    @(negedge clk);
    vld[0] = '0;
    for (k = 0; k < 20; k++) begin
      if (txs[0] == 2'b10) break;
      @(negedge clk);
    end
    rst = 1'b1;
    vld[0] = 4'b0100;
    @(negedge clk);
    rst = 1'b0;
    ptr[0] = 3;
    ptr[1] = 3;
    wait_hs(0, 30, at, rv, lows);
    e = pick(ptr[0], vld[0]);
    chk("rstmid_ready", 32'(rv), 32'(1 << e));
    chk("rstmid_hs_cycle", 32'(at - h), 32'd12);
    chk("rstmid_txstate_at_hs", 32'(txs[0]), 32'd0);
    chk("rstmid_send_low_before", 32'(snd[0]), 32'd0);
    ptr[0] = e;
    exp0.push_back(dat[0][8*e +: 8]);
    @(negedge clk);
    vld[0] = '0;
    chk("rstmid_send_rise", 32'(snd[0]), 32'd1);
    chk("rstmid_data", 32'(txd[0]), 32'h7E);
    wait_idle(0);

    // Valid pulse during WAIT_DONE: no ready, pointer untouched
    vld[0] = 4'b0001;
    dat[0] = 32'h00D2C7A1;
    wait_hs(0, 40, at, rv, lows);
    ptr[0] = 0;
    exp0.push_back(8'hA1);
    @(negedge clk);
    vld[0] = '0;
    repeat (4) @(negedge clk);
    vld[0] = 4'b0010;
    #1;
    chk("pulse_no_ready", 32'(rdy[0]), 32'd0);
    @(negedge clk);
    vld[0] = '0;
    wait_idle(0);
    vld[0] = 4'b0110;
    wait_hs(0, 40, at, rv, lows);
    e = pick(ptr[0], vld[0]);
    chk("pulse_ptr_ready", 32'(rv), 32'(1 << e));
    ptr[0] = e;
    exp0.push_back(dat[0][8*e +: 8]);
    @(negedge clk);
    vld[0] = '0;
    wait_idle(0);

    // Random traffic on the no-gap instance
    vld[0] = 4'($urandom_range(1, 15));
    dat[0] = $urandom();
    frames(0, 20, 1'b1);
    wait_idle(0);
    repeat (3) @(negedge clk);

    // Bytes seen by the transmitters, in order
    chk("frames0_count", 32'(frames0.size()), 32'(exp0.size()));
    for (int i = 0; i < frames0.size() && i < exp0.size(); i++)
      chk("frame0_byte", 32'(frames0[i]), 32'(exp0[i]));
    chk("frames3_count", 32'(frames3.size()), 32'(exp3.size()));
    for (int i = 0; i < frames3.size() && i < exp3.size(); i++)
      chk("frame3_byte", 32'(frames3[i]), 32'(exp3[i]));

    // Transmitter never leaves idle: watchdog behaviour (or indefinite wait)
    force_idle[0] = 1'b1;
    vld[0] = 4'b0001;
    dat[0] = 32'h0000005C;
    wait_hs(0, 40, at, rv, lows);
    @(negedge clk);
    vld[0] = '0;
    highs = 0;
    for (k = 1; k <= 40; k++) begin
      if (k > 1) @(negedge clk);
      if (snd[0]) highs++;
    end
`ifdef TX_ARB_TIMEOUT_EN
    chk("wd_send_cycles", 32'(highs), 32'd16);
    chk("wd_err_set", 32'(er[0]), 32'd1);
    chk("wd_back_idle", 32'(bsy[0]), 32'd0);
    repeat (5) @(negedge clk);
    chk("wd_err_sticky", 32'(er[0]), 32'd1);
`else
    chk("nowd_send_held", 32'(highs), 32'd40);
    chk("nowd_err_low", 32'(er[0]), 32'd0);
    chk("nowd_busy", 32'(bsy[0]), 32'd1);
`endif
    do_reset();
    force_idle[0] = 1'b0;
    chk("post_rst_err", 32'(er[0]), 32'd0);
    chk("post_rst_send", 32'(snd[0]), 32'd0);
    chk("post_rst_busy", 32'(bsy[0]), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
